// File: rtl/encode_prefix_serializer.sv
// Serializes one set of x86 prefix flags into legal prefix bytes, one per cycle, over a valid/ready stream.
// Optional branch-hint inputs in group 2 are enabled with `define PREFIX_BRANCH_HINT_EN.
module encode_prefix_serializer #(
  parameter int GROUP_ORDER_REVERSE = 0,
  parameter int ERROR_ON_CONFLICT   = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_req_valid,
  output logic       o_req_ready,
  input  logic       i_group_1_lock_bus,
  input  logic       i_group_1_repeat_not_equal,
  input  logic       i_group_1_repeat_equal,
  input  logic       i_group_2_segment_override,
  input  logic [2:0] i_segment_override_index,
  input  logic       i_group_3_operand_size,
  input  logic       i_group_4_address_size,
`ifdef PREFIX_BRANCH_HINT_EN
  input  logic       i_group_2_hint_branch_taken,
  input  logic       i_group_2_hint_branch_not_taken,
`endif
  output logic       o_byte_valid,
  input  logic       i_byte_ready,
  output logic [7:0] o_byte,
  output logic       o_byte_last,
  output logic       o_done,
  output logic       o_error,
  output logic [2:0] o_prefix_count
);

  typedef enum logic [1:0] {S_IDLE, S_EMIT, S_DONE} state_t;

  state_t     r_state;
  logic [3:0] r_mask;
  logic [7:0] r_code [4];
  logic [2:0] r_count;

  logic [1:0] w_g1_n;
  logic [7:0] w_g1_code;
  logic [7:0] w_seg_code;
  logic       w_seg_bad;
  logic       w_g2;
  logic [7:0] w_g2_code;
  logic       w_hint_bad;
  logic       w_err;
  logic [3:0] w_in_mask;
  logic [7:0] w_in_code [4];
  logic [1:0] w_in_sel;
  logic [1:0] w_sel;
  logic [3:0] w_rem;

  // Bit 0 is group 1; the configured order decides whether the lowest or highest pending bit goes first.
  function automatic logic [1:0] f_first(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    if (GROUP_ORDER_REVERSE != 0) begin
      for (int i = 0; i < 4; i++) if (m[i]) r = 2'(i);
    end else begin
      for (int i = 3; i >= 0; i--) if (m[i]) r = 2'(i);
    end
    return r;
  endfunction

  function automatic logic f_single(input logic [3:0] m);
    return (m != 4'd0) && ((m & (m - 4'd1)) == 4'd0);
  endfunction

  always_comb begin
    w_g1_n    = 2'(i_group_1_lock_bus) + 2'(i_group_1_repeat_not_equal) + 2'(i_group_1_repeat_equal);
    w_g1_code = i_group_1_lock_bus ? 8'hF0 : (i_group_1_repeat_not_equal ? 8'hF2 : 8'hF3);
    w_seg_bad = 1'b0;
    case (i_segment_override_index)
      3'd0:    w_seg_code = 8'h26;
      3'd1:    w_seg_code = 8'h2E;
      3'd2:    w_seg_code = 8'h36;
      3'd3:    w_seg_code = 8'h3E;
      3'd4:    w_seg_code = 8'h64;
      3'd5:    w_seg_code = 8'h65;
      default: begin
        w_seg_code = 8'h00;
        w_seg_bad  = i_group_2_segment_override;
      end
    endcase
`ifdef PREFIX_BRANCH_HINT_EN
    w_g2       = i_group_2_segment_override | i_group_2_hint_branch_taken | i_group_2_hint_branch_not_taken;
    w_hint_bad = (i_group_2_hint_branch_taken & i_group_2_hint_branch_not_taken) |
                 ((i_group_2_hint_branch_taken | i_group_2_hint_branch_not_taken) & i_group_2_segment_override);
    w_g2_code  = i_group_2_segment_override ? w_seg_code :
                 (i_group_2_hint_branch_taken ? 8'h3E : 8'h2E);
`else
    w_g2       = i_group_2_segment_override;
    w_hint_bad = 1'b0;
    w_g2_code  = w_seg_code;
`endif
    w_err = ((ERROR_ON_CONFLICT != 0) && (w_g1_n > 2'd1)) || w_seg_bad || w_hint_bad;
    w_in_mask    = {i_group_4_address_size, i_group_3_operand_size, w_g2, (w_g1_n != 2'd0)};
    w_in_code[0] = w_g1_code;
    w_in_code[1] = w_g2_code;
    w_in_code[2] = 8'h66;
    w_in_code[3] = 8'h67;
    w_in_sel = f_first(w_in_mask);
    w_sel    = f_first(r_mask);
    w_rem    = r_mask & ~(4'b0001 << w_sel);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= S_IDLE;
      r_mask         <= 4'd0;
      r_count        <= 3'd0;
      for (int i = 0; i < 4; i++) r_code[i] <= 8'h00;
      o_req_ready    <= 1'b1;
      o_byte_valid   <= 1'b0;
      o_byte         <= 8'h00;
      o_byte_last    <= 1'b0;
      o_done         <= 1'b0;
      o_error        <= 1'b0;
      o_prefix_count <= 3'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            o_req_ready <= 1'b0;
            r_count     <= 3'd0;
            for (int i = 0; i < 4; i++) r_code[i] <= w_in_code[i];
            if (w_err || (w_in_mask == 4'd0)) begin
              r_mask         <= 4'd0;
              r_state        <= S_DONE;
              o_done         <= 1'b1;
              o_error        <= w_err;
              o_prefix_count <= 3'd0;
            end else begin
              r_mask       <= w_in_mask;
              r_state      <= S_EMIT;
              o_byte_valid <= 1'b1;
              o_byte       <= w_in_code[w_in_sel];
              o_byte_last  <= f_single(w_in_mask);
            end
          end
        end
        S_EMIT: begin
          // Present the next byte right away so a held-high ready sees no bubble.
          if (i_byte_ready) begin
            r_mask  <= w_rem;
            r_count <= r_count + 3'd1;
            if (w_rem == 4'd0) begin
              r_state        <= S_DONE;
              o_byte_valid   <= 1'b0;
              o_byte_last    <= 1'b0;
              o_done         <= 1'b1;
              o_error        <= 1'b0;
              o_prefix_count <= r_count + 3'd1;
            end else begin
              o_byte      <= r_code[f_first(w_rem)];
              o_byte_last <= f_single(w_rem);
            end
          end
        end
        S_DONE: begin
          r_state     <= S_IDLE;
          o_done      <= 1'b0;
          o_error     <= 1'b0;
          o_req_ready <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_encode_prefix_serializer.sv
// Bench for encode_prefix_serializer: three configurations share one stimulus stream and are
// compared every cycle against a request-level model, plus literal byte/latency expectations.
module tb_encode_prefix_serializer;

  localparam int REV_P[3] = '{0, 0, 1};
  localparam int EOC_P[3] = '{1, 0, 1};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid = 1'b0;
  logic       lock = 1'b0, repne = 1'b0, rep = 1'b0, seg = 1'b0, op = 1'b0, addr = 1'b0;
  logic [2:0] idx = 3'd0;
  logic       byte_ready = 1'b1;

  logic       o_rdy [3];
  logic       o_bv  [3];
  logic [7:0] o_b   [3];
  logic       o_bl  [3];
  logic       o_dn  [3];
  logic       o_er  [3];
  logic [2:0] o_pc  [3];

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    encode_prefix_serializer #(
      .GROUP_ORDER_REVERSE(REV_P[gi]),
      .ERROR_ON_CONFLICT  (EOC_P[gi])
    ) u_dut (
      .i_clk                     (clk),
      .i_rst_n                   (rst_n),
      .i_req_valid               (req_valid),
      .o_req_ready               (o_rdy[gi]),
      .i_group_1_lock_bus        (lock),
      .i_group_1_repeat_not_equal(repne),
      .i_group_1_repeat_equal    (rep),
      .i_group_2_segment_override(seg),
      .i_segment_override_index  (idx),
      .i_group_3_operand_size    (op),
      .i_group_4_address_size    (addr),
`ifdef PREFIX_BRANCH_HINT_EN
      .i_group_2_hint_branch_taken    (1'b0),
      .i_group_2_hint_branch_not_taken(1'b0),
`endif
      .o_byte_valid              (o_bv[gi]),
      .i_byte_ready              (byte_ready),
      .o_byte                    (o_b[gi]),
      .o_byte_last               (o_bl[gi]),
      .o_done                    (o_dn[gi]),
      .o_error                   (o_er[gi]),
      .o_prefix_count            (o_pc[gi])
    );
  end

  task automatic chk(input string nm, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Request-level encoding: returns {err, n_bytes[2:0], bytes in emission order from bits [7:0] up}.
  function automatic logic [35:0] f_build(input int rev, input int eoc, input logic l, input logic rn,
                                          input logic r, input logic s, input logic [2:0] ix,
                                          input logic o, input logic a);
    logic [7:0]  g [4];
    logic        p [4];
    logic        err;
    int          n, n1, gsel;
    logic [31:0] bytes;
    logic [7:0]  seg_tab [6];
    seg_tab = '{8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65};
    err = 1'b0;
    n1 = int'(l) + int'(rn) + int'(r);
    p[0] = (n1 > 0);
    g[0] = l ? 8'hF0 : (rn ? 8'hF2 : 8'hF3);
    if (n1 > 1 && eoc != 0) err = 1'b1;
    p[1] = s;
    g[1] = (ix < 3'd6) ? seg_tab[ix] : 8'h00;
    if (s && ix > 3'd5) err = 1'b1;
    p[2] = o; g[2] = 8'h66;
    p[3] = a; g[3] = 8'h67;
    n = 0;
    bytes = 32'd0;
    for (int j = 0; j < 4; j++) begin
      gsel = (rev != 0) ? 3 - j : j;
      if (p[gsel]) begin
        bytes[8*n +: 8] = g[gsel];
        n++;
      end
    end
    if (err) n = 0;
    return {err, 3'(n), bytes};
  endfunction

  logic [35:0] exp_req [3];
  always_comb begin
    for (int k = 0; k < 3; k++)
      exp_req[k] = f_build(REV_P[k], EOC_P[k], lock, repne, rep, seg, idx, op, addr);
  end

  // Model: idle / pending bytes / one done cycle, advanced on each clock.
  bit          m_idle [3];
  bit          m_done [3];
  bit          m_err  [3];
  int          m_head [3];
  int          m_len  [3];
  int          m_cnt  [3];
  logic [31:0] m_bytes[3];

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        m_idle[k] <= 1'b1; m_done[k] <= 1'b0; m_err[k] <= 1'b0;
        m_head[k] <= 0; m_len[k] <= 0; m_cnt[k] <= 0;
      end else if (m_done[k]) begin
        m_done[k] <= 1'b0;
        m_idle[k] <= 1'b1;
      end else if (m_head[k] < m_len[k]) begin
        if (byte_ready) begin
          m_head[k] <= m_head[k] + 1;
          m_cnt[k]  <= m_cnt[k] + 1;
          if (m_head[k] + 1 == m_len[k]) begin
            m_done[k] <= 1'b1;
            m_err[k]  <= 1'b0;
          end
        end
      end else if (m_idle[k] && req_valid) begin
        m_idle[k] <= 1'b0;
        m_cnt[k]  <= 0;
        m_head[k] <= 0;
        if (exp_req[k][35] || exp_req[k][34:32] == 3'd0) begin
          m_done[k] <= 1'b1;
          m_err[k]  <= exp_req[k][35];
          m_len[k]  <= 0;
        end else begin
          m_len[k]   <= int'(exp_req[k][34:32]);
          m_bytes[k] <= exp_req[k][31:0];
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("req_ready[%0d]", k), int'(o_rdy[k]), int'(m_idle[k]));
      chk($sformatf("byte_valid[%0d]", k), int'(o_bv[k]), int'(m_head[k] < m_len[k]));
      if (o_bv[k] && m_head[k] < m_len[k]) begin
        chk($sformatf("byte[%0d]", k), int'(o_b[k]), int'(m_bytes[k][8*m_head[k] +: 8]));
        chk($sformatf("byte_last[%0d]", k), int'(o_bl[k]), int'(m_head[k] + 1 == m_len[k]));
      end
      chk($sformatf("done[%0d]", k), int'(o_dn[k]), int'(m_done[k]));
      if (m_done[k] && o_dn[k]) begin
        chk($sformatf("error[%0d]", k), int'(o_er[k]), int'(m_err[k]));
        chk($sformatf("prefix_count[%0d]", k), int'(o_pc[k]), m_err[k] ? 0 : m_cnt[k]);
      end
    end
  end

  // Capture of handshaken bytes and done pulses for the literal expectations.
  logic [7:0] cap [3][64];
  int cap_n [3] = '{0, 0, 0};
  int d_n   [3] = '{0, 0, 0};
  int d_cyc [3];
  int d_cnt [3];
  int d_err [3];

  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      for (int k = 0; k < 3; k++) begin
        if (o_bv[k] && byte_ready) begin
          cap[k][cap_n[k] % 64] <= o_b[k];
          cap_n[k] <= cap_n[k] + 1;
        end
        if (o_dn[k]) begin
          d_n[k]   <= d_n[k] + 1;
          d_cyc[k] <= cyc;
          d_cnt[k] <= int'(o_pc[k]);
          d_err[k] <= int'(o_er[k]);
        end
      end
    end
  end

  int cb [3];
  int db [3];
  int acc_cyc;

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      ok = m_idle[0] && m_idle[1] && m_idle[2];
    end
    if (!ok) chk("idle_timeout", 0, 1);
    #1;
  endtask

  task automatic set_flags(input logic l, input logic rn, input logic r, input logic s,
                           input logic [2:0] ix, input logic o, input logic a);
    lock = l; repne = rn; rep = r; seg = s; idx = ix; op = o; addr = a;
  endtask

  task automatic send(input logic l, input logic rn, input logic r, input logic s,
                      input logic [2:0] ix, input logic o, input logic a, input int stall);
    wait_idle();
    for (int k = 0; k < 3; k++) begin cb[k] = cap_n[k]; db[k] = d_n[k]; end
    set_flags(l, rn, r, s, ix, o, a);
    req_valid = 1'b1;
    acc_cyc = cyc;
    @(negedge clk); #1;
    req_valid = 1'b0;
    set_flags(1, 1, 1, 1, 3'd7, 1, 1);
    if (stall > 0) begin
      byte_ready = 1'b0;
      repeat (stall) @(negedge clk);
      #1 byte_ready = 1'b1;
    end
    wait_idle();
    $display("request l=%0d rn=%0d r=%0d s=%0d ix=%0d o=%0d a=%0d stall=%0d -> bytes %0d/%0d/%0d",
             l, rn, r, s, ix, o, a, stall, cap_n[0] - cb[0], cap_n[1] - cb[1], cap_n[2] - cb[2]);
  endtask

  // exp holds the expected bytes most significant first.
  task automatic expect_bytes(input int k, input int n, input logic [31:0] exp);
    chk($sformatf("nbytes[%0d]", k), cap_n[k] - cb[k], n);
    for (int i = 0; i < n && i < cap_n[k] - cb[k]; i++)
      chk($sformatf("seq[%0d][%0d]", k, i), int'(cap[k][(cb[k] + i) % 64]), int'(exp[8*(3-i) +: 8]));
  endtask

  task automatic expect_done(input int k, input int lat, input int cnt, input int err);
    chk($sformatf("ndone[%0d]", k), d_n[k] - db[k], 1);
    chk($sformatf("latency[%0d]", k), d_cyc[k] - acc_cyc, lat);
    chk($sformatf("count_lit[%0d]", k), d_cnt[k], cnt);
    chk($sformatf("error_lit[%0d]", k), d_err[k], err);
  endtask

  initial begin
    int dn_before;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_byte[%0d]", k), int'(o_b[k]), 0);
      chk($sformatf("rst_count[%0d]", k), int'(o_pc[k]), 0);
      chk($sformatf("rst_error[%0d]", k), int'(o_er[k]), 0);
      chk($sformatf("rst_ready[%0d]", k), int'(o_rdy[k]), 1);
    end
    rst_n = 1'b1;

    send(1, 0, 0, 1, 3'd4, 1, 1, 0);
    expect_bytes(0, 4, {8'hF0, 8'h64, 8'h66, 8'h67});
    expect_done(0, 5, 4, 0);
    expect_bytes(2, 4, {8'h67, 8'h66, 8'h64, 8'hF0});

    send(0, 0, 1, 0, 3'd0, 1, 0, 3);
    expect_bytes(0, 2, {8'hF3, 8'h66, 16'h0});
    expect_done(0, 6, 2, 0);

    send(0, 0, 0, 1, 3'd7, 0, 0, 0);
    expect_bytes(0, 0, 32'h0);
    expect_done(0, 1, 0, 1);

    send(1, 1, 0, 0, 3'd0, 0, 0, 0);
    expect_done(0, 1, 0, 1);
    expect_bytes(1, 1, {8'hF0, 24'h0});
    expect_done(1, 2, 1, 0);

    send(0, 0, 0, 0, 3'd0, 0, 0, 0);
    expect_done(0, 1, 0, 0);
    expect_done(2, 1, 0, 0);

    send(0, 0, 0, 1, 3'd1, 1, 1, 0);
    expect_bytes(2, 3, {8'h67, 8'h66, 8'h2E, 8'h00});
    expect_bytes(0, 3, {8'h2E, 8'h66, 8'h67, 8'h00});

    // Abort a request with reset once the first byte has been taken.
    wait_idle();
    dn_before = d_n[0];
    set_flags(1, 0, 0, 1, 3'd4, 1, 1);
    req_valid = 1'b1;
    @(negedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("abort_valid[%0d]", k), int'(o_bv[k]), 0);
      chk($sformatf("abort_done[%0d]", k), int'(o_dn[k]), 0);
    end
    @(negedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_no_done", d_n[0] - dn_before, 0);
    $display("reset abort done");

    send(0, 0, 0, 0, 3'd0, 1, 0, 0);
    expect_bytes(0, 1, {8'h66, 24'h0});
    expect_done(0, 2, 1, 0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
